// File: rtl/sensor_pkg.sv
// Shared types and default constants for the hazard-level sensor front end.
// Consumers: level_filter and sensor_level_encoder.
package sensor_pkg;

    typedef enum logic [1:0] {
        CH_RAIN  = 2'd0,
        CH_SEIS  = 2'd1,
        CH_WIND  = 2'd2,
        CH_LEVEL = 2'd3
    } channel_e;

    typedef logic [1:0] level_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_UPD  = 2'd3
    } state_e;

    localparam int DEF_ADC_W    = 8;
    localparam int DEF_TH1      = 64;
    localparam int DEF_TH2      = 128;
    localparam int DEF_TH3      = 192;
    localparam int DEF_HYST     = 8;
    localparam int DEF_PERSIST  = 3;
    localparam int DEF_SCAN_DIV = 1000;
    localparam int DEF_TIMEOUT  = 255;

    // Number of asserted threshold flags, which is directly a level code.
    function automatic level_t count3(input logic a, input logic b, input logic c);
        return level_t'({1'b0, a} + {1'b0, b} + {1'b0, c});
    endfunction

endpackage

// File: rtl/level_filter.sv
// One channel of quantizer + hysteresis + persistence filter.
// Updates only when i_en is high; i_clr forces the channel back to level 0.
module level_filter
    import sensor_pkg::*;
#(
    parameter int ADC_W   = DEF_ADC_W,
    parameter int TH1     = DEF_TH1,
    parameter int TH2     = DEF_TH2,
    parameter int TH3     = DEF_TH3,
    parameter int HYST    = DEF_HYST,
    parameter int PERSIST = DEF_PERSIST
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [ADC_W-1:0] i_sample,
    output level_t           o_level
);

    localparam int N_W = $clog2(PERSIST + 1);

    localparam logic [ADC_W-1:0] RISE1 = ADC_W'(TH1);
    localparam logic [ADC_W-1:0] RISE2 = ADC_W'(TH2);
    localparam logic [ADC_W-1:0] RISE3 = ADC_W'(TH3);
    localparam logic [ADC_W-1:0] FALL1 = ADC_W'(TH1 - HYST);
    localparam logic [ADC_W-1:0] FALL2 = ADC_W'(TH2 - HYST);
    localparam logic [ADC_W-1:0] FALL3 = ADC_W'(TH3 - HYST);
    localparam logic [N_W-1:0]   PERSIST_V = N_W'(PERSIST);

    level_t         r_level;
    level_t         r_pend;
    logic [N_W-1:0] r_cnt;

    level_t         w_q_up;
    level_t         w_q_dn;
    level_t         w_cand;
    logic [N_W-1:0] w_cnt_new;

    // Rising uses the plain thresholds, falling the lowered ones, so a
    // sample inside the hysteresis band keeps the committed level.
    always_comb begin
        w_q_up = count3(i_sample >= RISE1, i_sample >= RISE2, i_sample >= RISE3);
        w_q_dn = count3(i_sample >= FALL1, i_sample >= FALL2, i_sample >= FALL3);
        if (w_q_up > r_level)
            w_cand = w_q_up;
        else if (w_q_dn < r_level)
            w_cand = w_q_dn;
        else
            w_cand = r_level;
        w_cnt_new = (w_cand == r_pend) ? (r_cnt + N_W'(1)) : N_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_pend  <= '0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_level <= '0;
            r_pend  <= '0;
            r_cnt   <= '0;
        end else if (i_en) begin
            if (w_cand == r_level) begin
                r_cnt <= '0;
            end else begin
                r_pend <= w_cand;
                if (w_cnt_new == PERSIST_V) begin
                    r_level <= w_cand;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= w_cnt_new;
                end
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/sensor_level_encoder.sv
// Round-robin ADC poller producing filtered 2-bit hazard levels for 4 sensors.
// Optional macro ADC_TIMEOUT_EN adds a per-request response timeout and fault flags.
module sensor_level_encoder
    import sensor_pkg::*;
#(
    parameter int ADC_W    = DEF_ADC_W,
    parameter int TH1      = DEF_TH1,
    parameter int TH2      = DEF_TH2,
    parameter int TH3      = DEF_TH3,
    parameter int HYST     = DEF_HYST,
    parameter int PERSIST  = DEF_PERSIST,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int TIMEOUT  = DEF_TIMEOUT
)
(
    input  logic             clk,
    input  logic             rst_n,
    output logic             adc_req,
    output logic [1:0]       adc_ch,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             r1,
    output logic             r0,
    output logic             s1,
    output logic             s0,
    output logic             w1,
    output logic             w0,
    output logic             l1,
    output logic             l0,
    output logic             scan_done,
    output logic [3:0]       fault
);

    localparam int               SC_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(SCAN_DIV - 1);

    state_e           r_state;
    channel_e         r_ch;
    logic [SC_W-1:0]  r_scan_cnt;
    logic             r_wrap_pend;
    logic             r_scan_done;
    logic [ADC_W-1:0] r_sample;

    logic             w_scan_tick;
    logic             w_timeout;
    logic             w_advance;
    logic [3:0]       w_en;
    logic [3:0]       w_clr;
    level_t           w_level [4];

    assign w_scan_tick = (r_scan_cnt == SCAN_LAST);
    assign w_advance   = (r_state == ST_UPD) || w_timeout;

    // A wrap seen while a scan is still running is remembered so the next
    // scan starts on the first IDLE cycle instead of being skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ch        <= CH_RAIN;
            r_scan_cnt  <= '0;
            r_wrap_pend <= 1'b0;
            r_scan_done <= 1'b0;
            r_sample    <= '0;
        end else begin
            r_scan_cnt  <= w_scan_tick ? '0 : (r_scan_cnt + SC_W'(1));
            r_scan_done <= 1'b0;
            if (w_scan_tick && (r_state != ST_IDLE))
                r_wrap_pend <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_scan_tick || r_wrap_pend) begin
                        r_state     <= ST_REQ;
                        r_ch        <= CH_RAIN;
                        r_wrap_pend <= 1'b0;
                    end
                end
                ST_REQ:  r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (adc_valid) begin
                        r_sample <= adc_data;
                        r_state  <= ST_UPD;
                    end
                end
                default: ;
            endcase

            if (w_advance) begin
                if (r_ch == CH_LEVEL) begin
                    r_state     <= ST_IDLE;
                    r_scan_done <= 1'b1;
                end else begin
                    r_state <= ST_REQ;
                    r_ch    <= channel_e'(r_ch + 2'd1);
                end
            end
        end
    end

`ifdef ADC_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_wait_cnt;
    logic [3:0]      r_fault;

    assign w_timeout = (r_state == ST_WAIT) && !adc_valid && (r_wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_fault    <= '0;
        end else begin
            if (r_state == ST_REQ)
                r_wait_cnt <= '0;
            else if (r_state == ST_WAIT)
                r_wait_cnt <= r_wait_cnt + TO_W'(1);

            if (w_timeout)
                r_fault[r_ch] <= 1'b1;
            else if ((r_state == ST_WAIT) && adc_valid)
                r_fault[r_ch] <= 1'b0;
        end
    end

    assign fault = r_fault;
`else
    assign w_timeout = 1'b0;
    assign fault     = 4'b0000;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            assign w_en[gi]  = (r_state == ST_UPD) && (r_ch == channel_e'(gi));
            assign w_clr[gi] = w_timeout && (r_ch == channel_e'(gi));

            level_filter #(
                .ADC_W   (ADC_W),
                .TH1     (TH1),
                .TH2     (TH2),
                .TH3     (TH3),
                .HYST    (HYST),
                .PERSIST (PERSIST)
            ) u_filter (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_en     (w_en[gi]),
                .i_clr    (w_clr[gi]),
                .i_sample (r_sample),
                .o_level  (w_level[gi])
            );
        end
    endgenerate

    assign adc_req   = (r_state == ST_REQ);
    assign adc_ch    = r_ch;
    assign scan_done = r_scan_done;
    assign {r1, r0}  = w_level[0];
    assign {s1, s0}  = w_level[1];
    assign {w1, w0}  = w_level[2];
    assign {l1, l0}  = w_level[3];

endmodule

// File: tb/tb_sensor_level_encoder.sv
// Directed scoreboard bench for sensor_level_encoder (default parameters).
module tb_sensor_level_encoder;

    localparam int SCAN_DIV = 1000;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       adc_valid = 1'b0;
    logic [7:0] adc_data  = 8'd0;
    logic       adc_req;
    logic [1:0] adc_ch;
    logic       r1, r0, s1, s0, w1, w0, l1, l0;
    logic       scan_done;
    logic [3:0] fault;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         prev_t0  = -1;
    logic [7:0] prev_vec = 8'd0;
    logic [7:0] exp_q [$];
    logic [7:0] vec;

    assign vec = {r1, r0, s1, s0, w1, w0, l1, l0};

    sensor_level_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_req   (adc_req),
        .adc_ch    (adc_ch),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .r1        (r1),
        .r0        (r0),
        .s1        (s1),
        .s0        (s0),
        .w1        (w1),
        .w0        (w0),
        .l1        (l1),
        .l0        (l0),
        .scan_done (scan_done),
        .fault     (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (adc_req !== 1'b1 && n < SCAN_DIV + 64) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [1:0] chbits(input logic [7:0] v, input int ch);
        return v[7 - 2*ch -: 2];
    endfunction

    // One full scan: answer each request with latency ch+1, check the
    // 2-cycle commit latency per channel and the whole vector at scan_done.
    task automatic run_scan(input string name, input logic [7:0] sr, input logic [7:0] ss,
                            input logic [7:0] sw, input logic [7:0] sl,
                            input logic [7:0] exp_vec, input bit spur);
        logic [7:0] smp [4];
        logic [7:0] got;
        int n;
        smp[0] = sr; smp[1] = ss; smp[2] = sw; smp[3] = sl;
        exp_q.push_back(exp_vec);
        for (int ch = 0; ch < 4; ch++) begin
            wait_req(n);
            check({name, " req"}, 32'(adc_req), 32'd1);
            check({name, " adc_ch"}, 32'(adc_ch), ch);
            if (ch == 0) begin
                if (prev_t0 >= 0)
                    check({name, " period"}, cyc - prev_t0, SCAN_DIV);
                prev_t0 = cyc;
            end
            if (spur && ch == 0) begin
                adc_valid = 1'b1;
                adc_data  = 8'hFF;
            end
            tick();
            adc_valid = 1'b0;
            repeat (ch) tick();
            adc_valid = 1'b1;
            adc_data  = smp[ch];
            tick();
            adc_valid = 1'b0;
            check({name, " hold_in_upd"}, 32'(chbits(vec, ch)), 32'(chbits(prev_vec, ch)));
            tick();
            check({name, " commit"}, 32'(chbits(vec, ch)), 32'(chbits(exp_vec, ch)));
            if (ch == 3) begin
                check({name, " scan_done"}, 32'(scan_done), 32'd1);
                check({name, " sb_nonempty"}, exp_q.size(), 32'd1);
                got = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                check({name, " levels"}, 32'(vec), 32'(got));
                check({name, " fault"}, 32'(fault), 32'd0);
            end else begin
                check({name, " no_scan_done"}, 32'(scan_done), 32'd0);
            end
        end
        prev_vec = exp_vec;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset levels", 32'(vec), 32'd0);
        check("reset adc_req", 32'(adc_req), 32'd0);
        check("reset scan_done", 32'(scan_done), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        rst_n = 1'b1;

        wait_req(n);
        check("first_req_delay", n, SCAN_DIV);

        // rain/seismic/wind/level samples and the committed vector afterwards
        run_scan("S1",  8'd130, 8'd255, 8'd130, 8'd10,  8'h00, 1'b0);
        run_scan("S2",  8'd130, 8'd255, 8'd130, 8'd10,  8'h00, 1'b0);
        run_scan("S3",  8'd130, 8'd255, 8'd130, 8'd10,  8'hB8, 1'b0);
        run_scan("S4",  8'd130, 8'd255, 8'd120, 8'd130, 8'hB8, 1'b0);
        run_scan("S5",  8'd200, 8'd255, 8'd119, 8'd200, 8'hB8, 1'b1);
        run_scan("S6",  8'd130, 8'd255, 8'd119, 8'd130, 8'hB8, 1'b1);
        run_scan("S7",  8'd200, 8'd255, 8'd119, 8'd200, 8'hB4, 1'b0);
        run_scan("S8",  8'd200, 8'd0,   8'd119, 8'd130, 8'hB4, 1'b0);
        run_scan("S9",  8'd200, 8'd0,   8'd119, 8'd130, 8'hF4, 1'b0);
        run_scan("S10", 8'd200, 8'd0,   8'd119, 8'd130, 8'hC6, 1'b0);

        // Valid pulses while idle must not disturb anything.
        adc_valid = 1'b1;
        adc_data  = 8'd0;
        repeat (20) tick();
        adc_valid = 1'b0;
        check("idle_spur levels", 32'(vec), 32'(prev_vec));
        check("idle_spur adc_req", 32'(adc_req), 32'd0);

        // Reset in the middle of a WAIT.
        wait_req(n);
        check("rst_scan req", 32'(adc_req), 32'd1);
        check("rst_scan period", cyc - prev_t0, SCAN_DIV);
        tick();
        rst_n = 1'b0;
        #1;
        check("midwait_rst levels", 32'(vec), 32'd0);
        check("midwait_rst adc_req", 32'(adc_req), 32'd0);
        check("midwait_rst scan_done", 32'(scan_done), 32'd0);
        check("midwait_rst fault", 32'(fault), 32'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 8'd200;
        tick();
        adc_valid = 1'b0;
        check("late_valid adc_req", 32'(adc_req), 32'd0);
        wait_req(n);
        check("post_rst_req_delay", n + 1, SCAN_DIV);
        check("post_rst levels", 32'(vec), 32'd0);
        prev_t0  = -1;
        prev_vec = 8'd0;

        run_scan("S12", 8'd192, 8'd130, 8'd130, 8'd64, 8'h00, 1'b0);
        run_scan("S13", 8'd192, 8'd130, 8'd130, 8'd64, 8'h00, 1'b0);
        run_scan("S14", 8'd192, 8'd130, 8'd130, 8'd64, 8'hE9, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
